// File: rtl/deser_pkg.sv
// deser_pkg: shared types and defaults for the serial-link deserializer
//   state_t        HUNT / LOCKED alignment state
//   DATA_W_DEF     default word width (also the sync word length)
//   SYNC_WORD_DEF  default alignment marker, sent MSB first
//   MISS_W         width of the lock-timeout miss counter
package deser_pkg;
    typedef enum logic {HUNT, LOCKED} state_t;
    localparam int          DATA_W_DEF    = 32;
    localparam logic [31:0] SYNC_WORD_DEF = 32'hA5C3_3C5A;
    localparam int          MISS_W        = 8;
endpackage

// File: rtl/deser_lock_timer.sv
// deser_lock_timer: counts consecutive non-sync words and flags lock expiry
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         a sync word was seen; restart the count
//   inc         a non-sync word completed
//   expire      combinational: this inc reaches TIMEOUT (count restarts)
module deser_lock_timer
    import deser_pkg::*;
#(
    parameter logic [MISS_W-1:0] TIMEOUT = 8'd8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);
    logic [MISS_W-1:0] cnt_q, cnt_d;

    // The count never rests at TIMEOUT: the word that reaches it drops lock
    // and restarts the count in the same edge.
    always_comb begin
        expire = inc && (cnt_q >= TIMEOUT - MISS_W'(1));
        cnt_d  = (clr || expire) ? '0 : inc ? cnt_q + MISS_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/deserializer.sv
// deserializer: MSB-first serial-to-parallel receiver with sync-word alignment
//   clk, rst_n  clock, asynchronous active-low reset
//   bit_en      sample qualifier for serial_in
//   serial_in   serial data, MSB of each word first
//   data_out    last completed data word
//   data_valid  one-cycle strobe, data_out updated
//   locked      word alignment held
//   sync_pulse  one-cycle strobe, sync word recognised
//   lock_lost   one-cycle strobe, lock dropped by timeout
// Optional: define DESER_LOCK_TIMEOUT_EN to drop lock after SYNC_TIMEOUT
// consecutive non-sync words; otherwise lock is held until reset.
module deserializer
    import deser_pkg::*;
#(
    parameter int                DATA_W       = DATA_W_DEF,
    parameter logic [DATA_W-1:0] SYNC_WORD    = SYNC_WORD_DEF,
    parameter logic [MISS_W-1:0] SYNC_TIMEOUT = 8'd8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              locked,
    output logic              sync_pulse,
    output logic              lock_lost
);
    localparam int                CNT_W   = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, shift_next;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              data_valid_q, data_valid_d;
    logic              locked_q, locked_d;
    logic              sync_pulse_q, sync_pulse_d;
    logic              lock_lost_q, lock_lost_d;
    logic              is_sync, hunt_match, word_done, miss_inc, miss_clr, expire;

`ifdef DESER_LOCK_TIMEOUT_EN
    deser_lock_timer #(.TIMEOUT(SYNC_TIMEOUT)) u_lock_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (miss_clr),
        .inc    (miss_inc),
        .expire (expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = |SYNC_TIMEOUT;
    assign expire         = 1'b0;
`endif

    // Every strobe is qualified by bit_en, so idle edges deassert them.
    // Once locked only word boundaries are compared, so a sync pattern
    // straddling two words is treated as data.
    always_comb begin
        shift_next   = {shift_q[DATA_W-2:0], serial_in};
        is_sync      = shift_next == SYNC_WORD;
        hunt_match   = bit_en && state_q == HUNT && is_sync;
        word_done    = bit_en && state_q == LOCKED && bit_cnt_q == CNT_MAX;
        miss_inc     = word_done && !is_sync;
        miss_clr     = word_done && is_sync;
        shift_d      = bit_en ? shift_next : shift_q;
        state_d      = hunt_match ? LOCKED : expire ? HUNT : state_q;
        bit_cnt_d    = (bit_en && state_q == LOCKED) ? (word_done ? '0 : bit_cnt_q + CNT_W'(1)) : bit_cnt_q;
        data_out_d   = miss_inc ? shift_next : data_out_q;
        data_valid_d = miss_inc;
        sync_pulse_d = hunt_match || miss_clr;
        locked_d     = state_d == LOCKED;
        lock_lost_d  = expire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            sync_pulse_q <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            locked_q     <= locked_d;
            sync_pulse_q <= sync_pulse_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign locked     = locked_q;
    assign sync_pulse = sync_pulse_q;
    assign lock_lost  = lock_lost_q;
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed and random stimulus against a word-level reference model
module tb_deserializer;
    localparam logic [31:0] SYNC    = 32'hA5C3_3C5A;
    localparam int          TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_en = 1'b0;
    logic        serial_in = 1'b0;
    logic [31:0] data_out;
    logic        data_valid, locked, sync_pulse, lock_lost;

    int n_asserts = 0;
    int n_fail = 0;

    // reference model: last 32 bits seen, lock flag, bits into current word
    logic        m_locked = 1'b0;
    logic [31:0] m_win = '0;
    logic [31:0] m_data = '0;
    int          m_cnt = 0;
    int          m_miss = 0;
    logic        m_dv = 1'b0, m_sp = 1'b0, m_ll = 1'b0;

    deserializer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .locked     (locked),
        .sync_pulse (sync_pulse),
        .lock_lost  (lock_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all();
        chk("data_valid", {31'b0, data_valid}, {31'b0, m_dv});
        chk("sync_pulse", {31'b0, sync_pulse}, {31'b0, m_sp});
        chk("locked",     {31'b0, locked},     {31'b0, m_locked});
        chk("lock_lost",  {31'b0, lock_lost},  {31'b0, m_ll});
        chk("data_out",   data_out,            m_data);
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_win = '0; m_data = '0; m_cnt = 0; m_miss = 0;
        m_dv = 1'b0; m_sp = 1'b0; m_ll = 1'b0;
    endtask

    task automatic step(input logic b, input logic en);
        @(negedge clk);
        serial_in = b;
        bit_en = en;
        @(posedge clk);
        #1;
        m_dv = 1'b0; m_sp = 1'b0; m_ll = 1'b0;
        if (en) begin
            m_win = {m_win[30:0], b};
            if (!m_locked) begin
                if (m_win == SYNC) begin
                    m_locked = 1'b1; m_cnt = 0; m_sp = 1'b1;
                end
            end else begin
                m_cnt++;
                if (m_cnt == 32) begin
                    m_cnt = 0;
                    if (m_win == SYNC) begin
                        m_sp = 1'b1; m_miss = 0;
                    end else begin
                        m_dv = 1'b1; m_data = m_win; m_miss++;
`ifdef DESER_LOCK_TIMEOUT_EN
                        if (m_miss == TIMEOUT) begin
                            m_locked = 1'b0; m_ll = 1'b1; m_miss = 0;
                        end
`endif
                    end
                end
            end
        end
        chk_all();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) step(w[i], 1'b1);
    endtask

    function automatic logic [31:0] rand_data();
        logic [31:0] w;
        w = $urandom;
        while (w == SYNC) w = $urandom;
        return w;
    endfunction

    initial begin
        logic [31:0] w1, w2, w;
        repeat (2) @(posedge clk);
        #1;
        chk_all();
        @(negedge clk);
        rst_n = 1'b1;

        // all-zero stream never locks
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1);
        chk("zeros_locked", {31'b0, locked}, 32'd0);

        // junk, then sync, then first data word
        for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1);
        send_word(SYNC);
        chk("sync_locked", {31'b0, locked}, 32'd1);
        send_word(32'h1234_5678);
        chk("first_word", data_out, 32'h1234_5678);

        // sync then DEAD_BEEF with a 3-cycle bit_en gap mid-word
        send_word(SYNC);
        w = 32'hDEAD_BEEF;
        for (int i = 31; i >= 0; i--) begin
            if (i == 15) for (int k = 0; k < 3; k++) step(1'($urandom), 1'b0);
            step(w[i], 1'b1);
        end
        chk("gap_word", data_out, 32'hDEAD_BEEF);

        // sync pattern straddling a word boundary is plain data
        w1 = {4'h1, SYNC[31:4]};
        w2 = {SYNC[3:0], 28'h000_0123};
        send_word(w1);
        send_word(w2);
        chk("straddle_word", data_out, w2);
        chk("straddle_locked", {31'b0, locked}, 32'd1);

        // timeout sequence: sync clears misses, then 9 non-sync words
        send_word(SYNC);
        for (int n = 0; n < TIMEOUT + 1; n++) send_word(rand_data());
`ifdef DESER_LOCK_TIMEOUT_EN
        chk("timeout_unlocked", {31'b0, locked}, 32'd0);
`else
        chk("no_timeout_locked", {31'b0, locked}, 32'd1);
`endif

        // async reset 17 bits into a locked word
        send_word(SYNC);
        for (int i = 0; i < 17; i++) step(1'($urandom), 1'b1);
        @(negedge clk);
        bit_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_all();
        @(negedge clk);
        rst_n = 1'b1;
        send_word(SYNC);
        chk("relock", {31'b0, locked}, 32'd1);
        send_word(32'h0BAD_F00D);
        chk("relock_word", data_out, 32'h0BAD_F00D);

        // random traffic with random bit_en and embedded sync words
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 40; i++) step(1'($urandom), $urandom_range(0, 3) != 0);
            send_word(SYNC);
            for (int i = 0; i < 3; i++) send_word(rand_data());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
